// File: rtl/vx_exec_lane_split_pkg.sv
// Shared constants and request/packet structs for the warp-to-lane splitter.
// Packet count and PID width derive from the thread and lane counts below.
package VX_gpu_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int XLEN             = 32;
  localparam int NUM_THREADS      = 4;
  localparam int EXEC_NUM_LANES   = 1;
  localparam int EXEC_NUM_PACKETS = NUM_THREADS / EXEC_NUM_LANES;
  localparam int EXEC_PID_WIDTH   = log2up(EXEC_NUM_PACKETS);
  localparam int UUID_WIDTH       = 44;
  localparam int NW_WIDTH         = 2;
  localparam int NT_WIDTH         = log2up(NUM_THREADS);
  localparam int INST_OP_BITS     = 4;
  localparam int INST_MOD_BITS    = 3;
  localparam int NR_BITS          = 5;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                  uuid;
    logic [NW_WIDTH-1:0]                    wid;
    logic [NUM_THREADS-1:0]                 tmask;
    logic [INST_OP_BITS-1:0]                op_type;
    logic [INST_MOD_BITS-1:0]               op_mod;
    logic                                   wb;
    logic                                   use_PC;
    logic                                   use_imm;
    logic [XLEN-1:0]                        PC;
    logic [XLEN-1:0]                        imm;
    logic [NR_BITS-1:0]                     rd;
    logic [NT_WIDTH-1:0]                    tid;
    logic [NUM_THREADS-1:0][XLEN-1:0]       rs1_data;
    logic [NUM_THREADS-1:0][XLEN-1:0]       rs2_data;
    logic [NUM_THREADS-1:0][XLEN-1:0]       rs3_data;
    logic                                   is_mstore;
  } exec_req_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]                  uuid;
    logic [NW_WIDTH-1:0]                    wid;
    logic [EXEC_NUM_LANES-1:0]              tmask;
    logic [INST_OP_BITS-1:0]                op_type;
    logic [INST_MOD_BITS-1:0]               op_mod;
    logic                                   wb;
    logic                                   use_PC;
    logic                                   use_imm;
    logic [XLEN-1:0]                        PC;
    logic [XLEN-1:0]                        imm;
    logic [NR_BITS-1:0]                     rd;
    logic [NT_WIDTH-1:0]                    tid;
    logic [EXEC_NUM_LANES-1:0][XLEN-1:0]    rs1_data;
    logic [EXEC_NUM_LANES-1:0][XLEN-1:0]    rs2_data;
    logic [EXEC_NUM_LANES-1:0][XLEN-1:0]    rs3_data;
    logic                                   is_mstore;
    logic [EXEC_PID_WIDTH-1:0]              pid;
    logic                                   sop;
    logic                                   eop;
  } exec_pkt_t;

endpackage

// File: rtl/vx_exec_lane_split_priority_encoder.sv
// Lowest-set-bit priority encoder; index is 0 when no bit is set.
module VX_priority_encoder #(
  parameter int N  = 1,
  parameter int LN = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  data_in,
  output logic [LN-1:0] index,
  output logic          valid_out
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (data_in[i]) index = LN'(i);
    end
  end

  assign valid_out = |data_in;

endmodule

// File: rtl/vx_exec_lane_split.sv
// Splits a full-warp execute request into NUM_LANES-wide packets, emitting
// only packets with active threads, lowest index first, one per cycle.
module vx_exec_lane_split
  import VX_gpu_pkg::*;
#(
  parameter int NUM_LANES   = EXEC_NUM_LANES,
  parameter int NUM_PACKETS = NUM_THREADS / NUM_LANES,
  parameter int PID_WIDTH   = log2up(NUM_PACKETS)
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  input  exec_req_t in_data,
  output logic      in_ready,
  output logic      out_valid,
  output exec_pkt_t out_data,
  input  logic      out_ready
);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_SEND = 1'b1;

  logic [0:0]             state_reg, state_next;
  exec_req_t              req_reg;
  logic [NUM_PACKETS-1:0] rem_reg, rem_next;
  logic                   sop_reg, sop_next;
  logic [NUM_PACKETS-1:0] act_mask, act_mask_load;
  logic [PID_WIDTH-1:0]   pid;
  logic                   pid_valid;
  logic                   eop;
  logic                   fire_in, fire_out;

  for (genvar gi = 0; gi < NUM_PACKETS; gi++) begin : g_act
    assign act_mask[gi] = |in_data.tmask[gi*NUM_LANES +: NUM_LANES];
  end

  // An all-zero thread mask still produces a single packet 0.
  assign act_mask_load = (act_mask == '0) ? NUM_PACKETS'(1) : act_mask;

  VX_priority_encoder #(
    .N  (NUM_PACKETS),
    .LN (PID_WIDTH)
  ) pid_sel (
    .data_in   (rem_reg),
    .index     (pid),
    .valid_out (pid_valid)
  );

  // Last packet when at most one remaining bit is set.
  assign eop       = ((rem_reg & (rem_reg - NUM_PACKETS'(1))) == '0);
  assign out_valid = (state_reg == STATE_SEND) && pid_valid;
  assign fire_out  = out_valid && out_ready;
  assign in_ready  = reset && ((state_reg == STATE_IDLE) || (fire_out && eop));
  assign fire_in   = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    sop_next   = sop_reg;
    if (fire_out) begin
      rem_next = rem_reg & ~(NUM_PACKETS'(1) << pid);
      sop_next = 1'b0;
      if (eop) state_next = STATE_IDLE;
    end
    if (fire_in) begin
      state_next = STATE_SEND;
      rem_next   = act_mask_load;
      sop_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= STATE_IDLE;
      rem_reg   <= '0;
      sop_reg   <= 1'b0;
      req_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      sop_reg   <= sop_next;
      if (fire_in) req_reg <= in_data;
    end
  end

  always_comb begin
    out_data           = '0;
    out_data.uuid      = req_reg.uuid;
    out_data.wid       = req_reg.wid;
    out_data.op_type   = req_reg.op_type;
    out_data.op_mod    = req_reg.op_mod;
    out_data.wb        = req_reg.wb;
    out_data.use_PC    = req_reg.use_PC;
    out_data.use_imm   = req_reg.use_imm;
    out_data.PC        = req_reg.PC;
    out_data.imm       = req_reg.imm;
    out_data.rd        = req_reg.rd;
    out_data.tid       = req_reg.tid;
    out_data.is_mstore = req_reg.is_mstore;
    out_data.tmask     = req_reg.tmask[pid*NUM_LANES +: NUM_LANES];
    out_data.rs1_data  = req_reg.rs1_data[pid*NUM_LANES +: NUM_LANES];
    out_data.rs2_data  = req_reg.rs2_data[pid*NUM_LANES +: NUM_LANES];
    out_data.rs3_data  = req_reg.rs3_data[pid*NUM_LANES +: NUM_LANES];
    out_data.pid       = pid;
    out_data.sop       = sop_reg;
    out_data.eop       = eop;
  end

endmodule

// File: tb/tb_vx_exec_lane_split.sv
// Directed bench for the lane splitter at NUM_THREADS=4, NUM_LANES=1.
module tb_vx_exec_lane_split;
  import VX_gpu_pkg::*;

  logic      clk;
  logic      reset;
  logic      in_valid;
  exec_req_t in_data;
  logic      in_ready;
  logic      out_valid;
  exec_pkt_t out_data;
  logic      out_ready;

  int n_checks = 0;
  int n_pass   = 0;

  vx_exec_lane_split dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      tmask;
    int              n;
    logic [3:0][1:0] pids;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exec_req_t mk_req(input logic [43:0] uuid, input logic [3:0] tm);
    exec_req_t r;
    r           = '0;
    r.uuid      = uuid;
    r.wid       = 2'd2;
    r.tmask     = tm;
    r.op_type   = 4'h5;
    r.op_mod    = 3'h3;
    r.wb        = 1'b1;
    r.use_PC    = 1'b1;
    r.use_imm   = 1'b0;
    r.PC        = 32'h8000_1000;
    r.imm       = 32'h0000_0055;
    r.rd        = 5'd7;
    r.tid       = 2'd1;
    r.is_mstore = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r.rs1_data[i] = 32'hA0 + i;
      r.rs2_data[i] = 32'hB0 + i;
      r.rs3_data[i] = 32'hC0 + i;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exec_req_t r);
    in_data  = r;
    in_valid = 1'b1;
    check("accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Expected rs*_data for lane packet p equals thread p's operand.
  task automatic check_pkt(input string tag, input logic [43:0] uuid, input int pid,
                           input logic sop, input logic eop, input logic tm,
                           input logic exp_ready);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_pid"},   64'(out_data.pid), 64'(pid));
    check({tag, "_sop"},   64'(out_data.sop), 64'(sop));
    check({tag, "_eop"},   64'(out_data.eop), 64'(eop));
    check({tag, "_tmask"}, 64'(out_data.tmask), 64'(tm));
    check({tag, "_rs1"},   64'(out_data.rs1_data[0]), 64'(32'hA0 + pid));
    check({tag, "_rs2"},   64'(out_data.rs2_data[0]), 64'(32'hB0 + pid));
    check({tag, "_uuid"},  64'(out_data.uuid), 64'(uuid));
    check({tag, "_pc"},    64'(out_data.PC), 64'h8000_1000);
    check({tag, "_mst"},   64'(out_data.is_mstore), 64'd1);
    check({tag, "_ready"}, 64'(in_ready), 64'(exp_ready));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{tmask: 4'b1111, n: 4, pids: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[1] = '{tmask: 4'b1010, n: 2, pids: {2'd0, 2'd0, 2'd3, 2'd1}};
    vecs[2] = '{tmask: 4'b0000, n: 1, pids: {2'd0, 2'd0, 2'd0, 2'd0}};
    vecs[3] = '{tmask: 4'b0100, n: 1, pids: {2'd0, 2'd0, 2'd0, 2'd2}};
    vecs[4] = '{tmask: 4'b1001, n: 2, pids: {2'd0, 2'd0, 2'd3, 2'd0}};
    vecs[5] = '{tmask: 4'b0111, n: 3, pids: {2'd0, 2'd2, 2'd1, 2'd0}};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    tick();
    reset = 1'b1;
    #1;
    check("post_rst_ready", 64'(in_ready),  64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    tick();

    for (int v = 0; v < 6; v++) begin
      send(mk_req(44'(16 + v), vecs[v].tmask));
      for (int k = 0; k < vecs[v].n; k++) begin
        $display("vec %0d tmask %b pkt %0d pid %0d sop %0b eop %0b", v, vecs[v].tmask, k,
                 out_data.pid, out_data.sop, out_data.eop);
        check_pkt($sformatf("v%0d_k%0d", v, k), 44'(16 + v), int'(vecs[v].pids[k]),
                  k == 0, k == vecs[v].n - 1, vecs[v].tmask != 4'b0000,
                  k == vecs[v].n - 1);
        tick();
      end
      check($sformatf("v%0d_done", v), 64'(out_valid), 64'd0);
    end

    // Backpressure: pid1 held for four cycles before draining.
    send(mk_req(44'd3, 4'b1111));
    check_pkt("st_p0", 44'd3, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      $display("stall cycle %0d pid %0d valid %0b", k, out_data.pid, out_valid);
      check_pkt($sformatf("st_hold%0d", k), 44'd3, 1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int p = 1; p < 4; p++) begin
      check_pkt($sformatf("st_p%0d", p), 44'd3, p, p == 1 ? 1'b0 : 1'b0, p == 3, 1'b1, p == 3);
      tick();
    end
    check("st_done", 64'(out_valid), 64'd0);

    // Back-to-back: second request waits on in_valid, taken on first eop.
    send(mk_req(44'd1, 4'b1111));
    in_data  = mk_req(44'd2, 4'b1111);
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      $display("b2b cycle %0d uuid %0d pid %0d", k, out_data.uuid, out_data.pid);
      check_pkt($sformatf("b2b_%0d", k), (k < 4) ? 44'd1 : 44'd2, k % 4,
                (k % 4) == 0, (k % 4) == 3, 1'b1, (k % 4) == 3);
      tick();
      if (k == 3) in_valid = 1'b0;
    end
    check("b2b_done", 64'(out_valid), 64'd0);

    // Reset mid-request after pid1 is taken: nothing left over afterwards.
    send(mk_req(44'd4, 4'b1111));
    tick();
    tick();
    reset = 1'b0;
    #1;
    $display("reset asserted mid-request valid %0b ready %0b", out_valid, in_ready);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready),  64'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rel_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rel_idle%0d", k), 64'(out_valid), 64'd0);
      tick();
    end

    // Normal operation resumes after the mid-request reset.
    send(mk_req(44'd5, 4'b0010));
    check_pkt("resume", 44'd5, 1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("resume_done", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vx_exec_lane_split.md
VX_EXEC_LANE_SPLIT -- requirements
Module: VX_exec_lane_split

Interface
REQ-001 SHALL have parameter NUM_LANES, default 1, lanes per output packet; NUM_THREADS SHALL be divisible by NUM_LANES.
REQ-002 SHALL have derived parameter NUM_PACKETS, default NUM_THREADS/NUM_LANES, packets per warp request.
REQ-003 SHALL have derived parameter PID_WIDTH, default LOG2UP(NUM_PACKETS), packet index width.
REQ-004 clk  in  1  single clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  full-warp execute request valid.
REQ-007 in_data  in  request struct  uuid, wid, tmask[NUM_THREADS], op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, tid, rs1/rs2/rs3_data[NUM_THREADS][XLEN], is_mstore.
REQ-008 in_ready  out  1  request accepted when in_valid & in_ready.
REQ-009 out_valid  out  1  lane packet valid.
REQ-010 out_data  out  execute packet struct  same scalar fields, tmask/rs*_data sliced to NUM_LANES, plus pid, sop, eop.
REQ-011 out_ready  in  1  downstream functional unit accepts packet.

Function
REQ-012 Packet p SHALL be active iff tmask[p*NUM_LANES +: NUM_LANES] != 0; active packets SHALL be emitted in ascending p; inactive packets SHALL be skipped with no bubble.
REQ-013 If tmask == 0, exactly one packet SHALL be emitted: pid=0, sop=eop=1, tmask=0.
REQ-014 Packet p: pid=p, tmask/rs1/rs2/rs3_data = slice p; uuid, wid, op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, tid, is_mstore copied unchanged.
REQ-015 sop=1 on first emitted packet of a request only; eop=1 on last active packet only; single active packet has sop=eop=1.
REQ-016 FSM IDLE/SEND: IDLE --accept--> SEND; SEND --eop packet accepted, no new accept--> IDLE; SEND --eop accepted with simultaneous new accept--> SEND for new request.
REQ-017 in_ready SHALL be 1 in IDLE, and in SEND only in the cycle the eop packet is accepted (out_valid & out_ready & eop); else 0.
REQ-018 First packet SHALL appear on out_valid the cycle after acceptance (latency 1); steady throughput one packet/cycle with out_ready=1.
REQ-019 While out_valid & !out_ready, out_data SHALL remain stable and out_valid SHALL stay 1.
REQ-020 Remaining-active mask SHALL clear the current packet's bit on each accepted packet; next pid = lowest remaining set bit.
REQ-021 NUM_PACKETS==1: SHALL act as a one-entry pipeline register, pid=0, sop=eop=1.

Reset
REQ-022 Reset assertion SHALL immediately force out_valid=0, in_ready=0, state IDLE, pid=0, remaining mask=0.
REQ-023 Reset mid-request SHALL discard remaining packets; after deassertion in_ready=1 next cycle and no residual packet emitted.

Structure
REQ-024 Packet-count/PID-width constants and the request/packet struct typedefs SHALL reside in VX_gpu_pkg.
REQ-025 Next-active-packet selection SHALL use one sub-module instance, VX_priority_encoder (N=NUM_PACKETS).

Verification (NUM_THREADS=4, NUM_LANES=1)
REQ-026 tmask=4'b1111, out_ready=1 -> pid 0,1,2,3 on cycles 1-4, sop at pid0, eop at pid3, in_ready=1 on cycle 4.
REQ-027 tmask=4'b1010, rs1_data={D,C,B,A} -> two packets: pid1 rs1=B sop=1 eop=0; pid3 rs1=D sop=0 eop=1.
REQ-028 tmask=4'b1111, out_ready=0 for 3 cycles at pid1 -> pid1 data held stable 4 cycles, then pid2, pid3.
REQ-029 Two back-to-back tmask=4'b1111 requests, out_ready=1 -> 8 packets in 8 consecutive cycles, second request accepted on eop cycle of first.
REQ-030 reset low after pid1 accepted -> out_valid=0 immediately; after release in_ready=1, pid2/pid3 never appear.
REQ-031 tmask=4'b0000 -> one packet pid0, sop=eop=1, tmask=0.
